component_regs_slave: RTL and testbench



---
 rtl/my_registers_pkg.sv | 35 +++
 rtl/component_regs_fsm.sv | 69 ++++++
 rtl/component_regs_slave.sv | 107 ++++++++++
 tb/tb_component_regs_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/my_registers_pkg.sv
// Register layout shared by component_regs_slave and my_sub_module.
// Defines the packed component register block, its read/write masks and the
// handshake FSM state type used by the slave.
package my_registers;

    typedef logic [31:0] bus_word_t;

    typedef struct packed {
        logic [7:0]  major;
        logic [7:0]  minor;
        logic [15:0] patch;
    } version_register_t;

    // First member is the MSB end: word 1 = {memory_offset, stat_depth, stat_width}, word 0 = version.
    typedef struct packed {
        logic [15:0]       memory_offset;
        logic [7:0]        stat_depth;
        logic [7:0]        stat_width;
        version_register_t version;
    } component_registers_t;

    localparam int REG_WORDS = $bits(component_registers_t) / 32;

    // Every bit is readable.
    localparam logic [$bits(component_registers_t)-1:0] reg_read_mask_bits = '1;

    // The version word is read-only; the configuration word is fully writable.
    localparam logic [$bits(component_registers_t)-1:0] reg_write_mask_bits = {32'hFFFF_FFFF, 32'h0000_0000};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/component_regs_fsm.sv
// Request/response handshake control for component_regs_slave.
// IDLE accepts one request, RESP holds the registered response until the
// master takes it. At most one access per two cycles.
module component_regs_fsm
    import my_registers::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        accept,
    input  logic [31:0] rdata_in,
    input  logic        error_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    fsm_state_e  state_q, state_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Next state: accept in IDLE, release on the response handshake.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state only.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        accept    = req_valid && (state_q == ST_IDLE);
    end

    // Response capture at the accept edge; held stable while in RESP.
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        if (accept) begin
            rsp_rdata_d = rdata_in;
            rsp_error_d = error_in;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: rtl/component_regs_slave.sv
// Word-addressed register slave owning the live component_registers_t.
// Word n = regs[32n+31:32n]; reads apply READ_MASK, writes merge under WRITE_MASK,
// out-of-range addresses answer with error=1 and change nothing.
// Optional feature macro COMPONENT_REGS_ACCESS_COUNT_EN: adds a read-only saturating
// count of accepted accesses at word address NWORDS (count includes the access reading it).
module component_regs_slave
    import my_registers::*;
#(
    parameter int                       REGISTER_BITS = $bits(component_registers_t),
    parameter logic [REGISTER_BITS-1:0] READ_MASK     = '1,
    parameter logic [REGISTER_BITS-1:0] WRITE_MASK    = REGISTER_BITS'(reg_write_mask_bits),
    parameter logic [REGISTER_BITS-1:0] RESET_VALUE   = '0,
    parameter int                       ADDR_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_error,
    output logic [REGISTER_BITS-1:0] regs_o
);

    localparam int NWORDS = REGISTER_BITS / 32;

    logic [REGISTER_BITS-1:0] regs_q, regs_d;
    logic                     accept;
    logic [31:0]              rd_word;
    logic                     rd_error;

`ifdef COMPONENT_REGS_ACCESS_COUNT_EN
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(NWORDS);
    logic [31:0] acc_cnt_q, acc_cnt_d;

    // Access counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_cnt_q <= '0;
        else     acc_cnt_q <= acc_cnt_d;
    end

    // Count every accepted access, sticking at all-ones.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (accept && (acc_cnt_q != 32'hFFFF_FFFF)) acc_cnt_d = acc_cnt_q + 32'd1;
    end
`endif

    // Live register contents; reset restores the configured reset image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= RESET_VALUE;
        else     regs_q <= regs_d;
    end

    // Write merge: only WRITE_MASK bits of the addressed word take new data.
    always_comb begin
        regs_d = regs_q;
        if (accept && req_write) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (req_addr == ADDR_W'(w)) begin
                    regs_d[32*w +: 32] = (regs_q[32*w +: 32] & ~WRITE_MASK[32*w +: 32])
                                       | (req_wdata          &  WRITE_MASK[32*w +: 32]);
                end
            end
        end
    end

    // Address decode and read data; writes and errors respond with zero data.
    always_comb begin
        rd_word  = '0;
        rd_error = 1'b1;
        for (int w = 0; w < NWORDS; w++) begin
            if (req_addr == ADDR_W'(w)) begin
                rd_error = 1'b0;
                if (!req_write) rd_word = regs_q[32*w +: 32] & READ_MASK[32*w +: 32];
            end
        end
`ifdef COMPONENT_REGS_ACCESS_COUNT_EN
        // The counter word is unmasked and returns the count including this access.
        if (req_addr == CNT_ADDR) begin
            rd_error = 1'b0;
            if (!req_write) rd_word = acc_cnt_d;
        end
`endif
    end

    component_regs_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .accept    (accept),
        .rdata_in  (rd_word),
        .error_in  (rd_error),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    assign regs_o = regs_q;

endmodule

// File: tb/tb_component_regs_slave.sv
// Bench for component_regs_slave: two instances share one request stream,
// one with a full read mask and one with READ_MASK=64'h0000_FFFF_0000_0000.
// A word-array model predicts responses and register contents.
module tb_component_regs_slave;

    localparam logic [63:0] RV    = 64'h1234_5678_0001_2003;
    localparam logic [63:0] RM_A  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RM_B  = 64'h0000_FFFF_0000_0000;
    localparam logic [63:0] WMASK = {32'hFFFF_FFFF, 32'h0000_0000};
    localparam int          NW    = 2;
`ifdef COMPONENT_REGS_ACCESS_COUNT_EN
    localparam int          NADDR = NW + 1;
`else
    localparam int          NADDR = NW;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_error;
    logic [31:0] a_rsp_rdata;
    logic [63:0] a_regs;
    logic        b_req_ready, b_rsp_valid, b_rsp_error;
    logic [31:0] b_rsp_rdata;
    logic [63:0] b_regs;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m_word [NW];
    logic [31:0] m_cnt;
    logic [31:0] exp_rd_a, exp_rd_b;
    logic        exp_err;

    component_regs_slave #(.RESET_VALUE(RV)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error), .regs_o(a_regs)
    );

    component_regs_slave #(.RESET_VALUE(RV), .READ_MASK(RM_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error), .regs_o(b_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_word[0] = RV[31:0];
        m_word[1] = RV[63:32];
        m_cnt     = '0;
    endtask

    function automatic logic [63:0] model_regs();
        return {m_word[1], m_word[0]};
    endfunction

    // Apply one accepted access to the model and set the expected response.
    task automatic model_access(input logic wr, input int addr, input logic [31:0] wd);
        logic [31:0] wm, rma, rmb;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        exp_rd_a = '0;
        exp_rd_b = '0;
        exp_err  = 1'b0;
        if (addr < NW) begin
            wm  = WMASK[32*addr +: 32];
            rma = RM_A[32*addr +: 32];
            rmb = RM_B[32*addr +: 32];
            if (wr) m_word[addr] = (m_word[addr] & ~wm) | (wd & wm);
            else begin
                exp_rd_a = m_word[addr] & rma;
                exp_rd_b = m_word[addr] & rmb;
            end
        end else if (addr < NADDR) begin
            if (!wr) begin
                exp_rd_a = m_cnt;
                exp_rd_b = m_cnt;
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic check_resp(input string tag);
        check({tag, ":a_valid"}, a_rsp_valid, 1);
        check({tag, ":b_valid"}, b_rsp_valid, 1);
        check({tag, ":a_ready"}, a_req_ready, 0);
        check({tag, ":a_rdata"}, a_rsp_rdata, exp_rd_a);
        check({tag, ":b_rdata"}, b_rsp_rdata, exp_rd_b);
        check({tag, ":a_error"}, a_rsp_error, exp_err);
        check({tag, ":b_error"}, b_rsp_error, exp_err);
        check({tag, ":a_regs"}, a_regs, model_regs());
        check({tag, ":b_regs"}, b_regs, model_regs());
    endtask

    // One access: called just after a falling edge; returns just after a falling edge.
    // While the response is held, a stray request is presented and must not be taken.
    task automatic access(input logic wr, input logic [3:0] addr, input logic [31:0] wd, input int hold);
        check("idle:a_ready", a_req_ready, 1);
        check("idle:b_ready", b_req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b0;
        @(posedge clk);
        model_access(wr, int'(addr), wd);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = $urandom;
        @(negedge clk);
        check_resp("accept");
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 4'($urandom_range(0, NADDR));
            req_wdata = $urandom;
            @(negedge clk);
            check_resp("hold");
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("done:a_valid", a_rsp_valid, 0);
        check("done:b_valid", b_rsp_valid, 0);
        check("done:a_regs", a_regs, model_regs());
    endtask

    initial begin
        logic [3:0] addr;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst:a_ready", a_req_ready, 1);
        check("rst:a_valid", a_rsp_valid, 0);
        check("rst:a_rdata", a_rsp_rdata, 0);
        check("rst:a_error", a_rsp_error, 0);
        check("rst:a_regs", a_regs, RV);
        check("rst:b_regs", b_regs, RV);
        rst = 1'b0;
        @(negedge clk);

        // Directed sequence
        access(1'b0, 4'd0, 32'h0, 0);
        access(1'b1, 4'd1, 32'hDEAD_BEEF, 0);
        access(1'b0, 4'd1, 32'h0, 1);
        access(1'b1, 4'd0, 32'hFFFF_FFFF, 0);
        access(1'b0, 4'd5, 32'h0, 0);
        access(1'b0, 4'd2, 32'h0, 0);
        access(1'b1, 4'd2, 32'h5555_AAAA, 0);

        // Long stall on the response channel
        access(1'b0, 4'd1, 32'h0, 4);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) addr = 4'($urandom_range(0, NADDR));
            else                           addr = 4'($urandom_range(0, 15));
            access(1'($urandom), addr, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while a response is pending
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd1;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        model_access(1'b1, 1, 32'hCAFE_F00D);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_resp("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst:a_valid", a_rsp_valid, 0);
        check("midrst:a_ready", a_req_ready, 1);
        check("midrst:a_rdata", a_rsp_rdata, 0);
        check("midrst:a_regs", a_regs, RV);
        check("midrst:b_regs", b_regs, RV);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 4'd1, 32'h0, 0);
        access(1'b0, 4'd2, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
